// File: rtl/store_write_buffer_pkg.sv
// Shared types and helpers for the store write buffer.
package store_write_buffer_pkg;

   // One buffered store: word address, merged lane enables, merged data and
   // the cache-management flag. The valid bit is kept separately so it can be
   // reset without resetting the payload.
   typedef struct packed {
      logic [29:0] word_addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic        cache_op;
   } wb_entry_t;

   // Replace the bytes of old_data selected by be with the bytes of new_data.
   function automatic logic [31:0] merge_lanes(
      input logic [31:0] old_data,
      input logic [31:0] new_data,
      input logic [3:0]  be
   );
      logic [31:0] result;
      result = old_data;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) result[8*i +: 8] = new_data[8*i +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/store_write_buffer.sv
// Store write buffer: a small in-order FIFO between the store queue and the
// data-cache write port. Back-to-back stores to the same word merge into the
// youngest entry; entries drain oldest-first over a valid/ready port, and a
// load word address is checked against every buffered entry.
module store_write_buffer
   import store_write_buffer_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter bit ENABLE_MERGE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        sq_valid,
   input  logic [31:0] sq_addr,
   input  logic [3:0]  sq_be,
   input  logic [31:0] sq_data,
   input  logic        sq_cache_op,
   output logic        sq_pop,

   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_data,
   output logic        mem_cache_op,

   input  logic [29:0] load_addr,
   output logic        load_conflict,

   input  logic        drain_req,
   output logic        empty,
   output logic        full
);

   localparam int             PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

   wb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] valid;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] youngest;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;

   logic merge;
   logic accept;
   logic push;
   logic merge_en;
   logic pop;

   // The two low address bits only select lanes, which sq_be already encodes.
   logic unused_addr_bits;
   assign unused_addr_bits = ^sq_addr[1:0];

   assign youngest = tail - PTR_W'(1);

   // Merge decision: same word as the youngest entry, neither side a cache op,
   // merging not suppressed, and never touching an entry on the mem port.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      merge = 1'b0;
      if (ENABLE_MERGE && sq_valid && !drain_req && !sq_cache_op &&
          (count != '0) &&
          !entries[youngest].cache_op &&
          (entries[youngest].word_addr == sq_addr[31:2]) &&
          ((youngest != head) || !mem_valid)) begin
         merge = 1'b1;
      end
   end

   // A store is taken when it merges or a free slot exists at cycle start;
   // nothing is popped from the store queue while reset is asserted.
   assign accept   = sq_valid && !rst && (merge || !full);
   assign sq_pop   = accept;
   assign push     = accept && !merge;
   assign merge_en = accept && merge;

   // Oldest entry goes straight to the memory port.
   assign mem_valid    = !empty;
   assign mem_addr     = entries[head].word_addr;
   assign mem_be       = entries[head].be;
   assign mem_data     = entries[head].data;
   assign mem_cache_op = entries[head].cache_op;
   assign pop          = mem_valid && mem_ready;

   assign count_next = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

   // Pointer, occupancy and valid-bit state; reset drops every entry and any
   // in-flight handshake.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + PTR_W'(1);
         end
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == COUNT_FULL);
      end
   end

   // Entry payload: allocate at the tail or merge lanes into the youngest.
   always_ff @(posedge clk) begin
      // NOTE: the payload array is deliberately not reset; the valid bits and
      // pointers decide what is live, so stale payload is never observed.
      if (push) begin
         entries[tail] <= '{word_addr: sq_addr[31:2],
                            be:        sq_be,
                            data:      sq_data,
                            cache_op:  sq_cache_op};
      end else if (merge_en) begin
         entries[youngest].be   <= entries[youngest].be | sq_be;
         entries[youngest].data <= merge_lanes(entries[youngest].data, sq_data, sq_be);
      end
   end

   // Load-address conflict: any live entry at the load's word, cache ops
   // included so the check stays conservative.
   logic [DEPTH-1:0] conflict_hit;

   for (genvar g = 0; g < DEPTH; g++) begin : g_conflict
      assign conflict_hit[g] = valid[g] && (entries[g].word_addr == load_addr);
   end

   assign load_conflict = |conflict_hit;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_store_write_buffer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        sq_valid;
   logic [31:0] sq_addr;
   logic [3:0]  sq_be;
   logic [31:0] sq_data;
   logic        sq_cache_op;
   logic        sq_pop;
   logic        mem_valid;
   logic        mem_ready;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_data;
   logic        mem_cache_op;
   logic [29:0] load_addr;
   logic        load_conflict;
   logic        drain_req;
   logic        empty;
   logic        full;

   store_write_buffer #(.DEPTH(DEPTH), .ENABLE_MERGE(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .sq_valid     (sq_valid),
      .sq_addr      (sq_addr),
      .sq_be        (sq_be),
      .sq_data      (sq_data),
      .sq_cache_op  (sq_cache_op),
      .sq_pop       (sq_pop),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_data     (mem_data),
      .mem_cache_op (mem_cache_op),
      .load_addr    (load_addr),
      .load_conflict(load_conflict),
      .drain_req    (drain_req),
      .empty        (empty),
      .full         (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an in-order list of buffered stores.
   typedef struct {
      logic [29:0] word;
      logic [3:0]  be;
      logic [31:0] data;
      logic        cop;
   } model_entry_t;

   model_entry_t model_q[$];

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_in(input logic v, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic cop, input logic rdy,
                         input logic [29:0] ld, input logic drn);
      sq_valid    = v;
      sq_addr     = a;
      sq_be       = be;
      sq_data     = d;
      sq_cache_op = cop;
      mem_ready   = rdy;
      load_addr   = ld;
      drain_req   = drn;
   endtask

   // One clock: compare outputs against the model, then advance the model.
   // Entered 1 time unit after a posedge with inputs already applied.
   task automatic step();
      int           n;
      logic         exp_mv, exp_full, exp_lc, do_merge, exp_pop;
      model_entry_t e;
      #2;
      n        = model_q.size();
      exp_mv   = (n != 0);
      exp_full = (n == DEPTH);
      exp_lc   = 1'b0;
      foreach (model_q[i]) if (model_q[i].word == load_addr) exp_lc = 1'b1;
      do_merge = sq_valid && !drain_req && !sq_cache_op && (n >= 1);
      if (do_merge) begin
         do_merge = !model_q[n-1].cop && (model_q[n-1].word == sq_addr[31:2]) &&
                    ((n > 1) || !exp_mv);
      end
      exp_pop = sq_valid && (do_merge || !exp_full);

      check("mem_valid", 32'(mem_valid), 32'(exp_mv));
      check("empty", 32'(empty), 32'(!exp_mv));
      check("full", 32'(full), 32'(exp_full));
      check("sq_pop", 32'(sq_pop), 32'(exp_pop));
      check("load_conflict", 32'(load_conflict), 32'(exp_lc));
      if (exp_mv) begin
         check("mem_addr", 32'(mem_addr), 32'(model_q[0].word));
         check("mem_be", 32'(mem_be), 32'(model_q[0].be));
         check("mem_data", mem_data, model_q[0].data);
         check("mem_cache_op", 32'(mem_cache_op), 32'(model_q[0].cop));
      end

      if (exp_pop && do_merge) begin
         for (int b = 0; b < 4; b++) begin
            if (sq_be[b]) model_q[n-1].data[8*b +: 8] = sq_data[8*b +: 8];
         end
         model_q[n-1].be = model_q[n-1].be | sq_be;
      end
      if (exp_mv && mem_ready) void'(model_q.pop_front());
      if (exp_pop && !do_merge) begin
         e.word = sq_addr[31:2];
         e.be   = sq_be;
         e.data = sq_data;
         e.cop  = sq_cache_op;
         model_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b1, $urandom, 4'($urandom), $urandom, 1'b1, 1'b1, 30'($urandom), 1'b0);
      @(posedge clk);
      #1;
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_load_conflict", 32'(load_conflict), 32'd0);
      check("rst_sq_pop", 32'(sq_pop), 32'd0);
      model_q.delete();
      rst = 1'b0;
      set_in(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 30'h3FFFFFFF, 1'b0);
      step();
   endtask

   task automatic drain_all();
      int k;
      k = 0;
      set_in(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 30'h3FFFFFFF, 1'b0);
      while (model_q.size() != 0 && k < 4 * DEPTH) begin
         step();
         k++;
      end
      check("drain_empty", 32'(empty), 32'd1);
   endtask

   initial begin
      logic [29:0] word;
      rst = 1'b1;
      do_reset();

      // Merge into the youngest entry while an older entry sits on the port.
      set_in(1'b1, 32'h200, 4'b1111, 32'h11223344, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      set_in(1'b1, 32'h100, 4'b0001, 32'h000000AA, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      set_in(1'b1, 32'h102, 4'b1100, 32'hBBBB0000, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      set_in(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 30'h0, 1'b0);
      step();
      check("merge_be", 32'(mem_be), 32'b1101);
      check("merge_data", mem_data, 32'hBBBB00AA);
      step();
      check("merge_one_entry", 32'(empty), 32'd1);

      // Fill, refuse while full, no same-cycle reuse of a drained slot.
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 32'h300 + 32'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0, 30'h0, 1'b0);
         step();
      end
      check("fill_full", 32'(full), 32'd1);
      set_in(1'b1, 32'h310, 4'hF, 32'h55555555, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      set_in(1'b1, 32'h310, 4'hF, 32'h55555555, 1'b0, 1'b1, 30'h0, 1'b0);
      step();
      set_in(1'b1, 32'h310, 4'hF, 32'h55555555, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      drain_all();

      // Single entry on the port: same-word store must allocate, not merge.
      set_in(1'b1, 32'h500, 4'hF, 32'h12345678, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      set_in(1'b1, 32'h501, 4'b0010, 32'h0000EE00, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      check("nomerge_head_data", mem_data, 32'h12345678);
      drain_all();

      // Cache op followed by a store to the same word drains in order.
      set_in(1'b1, 32'h600, 4'h0, 32'h0, 1'b1, 1'b0, 30'h0, 1'b0);
      step();
      set_in(1'b1, 32'h600, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 30'h0, 1'b0);
      step();
      check("cop_first", 32'(mem_cache_op), 32'd1);
      set_in(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 30'h0, 1'b0);
      step();
      check("cop_second", 32'(mem_cache_op), 32'd0);
      drain_all();

      // Load conflict appears while buffered and clears after the drain.
      set_in(1'b1, 32'h100, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 30'h40, 1'b0);
      step();
      set_in(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 30'h40, 1'b0);
      step();
      check("conflict_set", 32'(load_conflict), 32'd1);
      set_in(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 30'h40, 1'b0);
      step();
      check("conflict_clear", 32'(load_conflict), 32'd0);

      // Pointer wrap over several laps.
      for (int i = 0; i < 3 * DEPTH; i++) begin
         set_in(1'b1, 32'h1000 + 32'(4 * i), 4'hF, 32'(i) * 32'h01010101, 1'b0,
                1'(i % 2), 30'h0, 1'b0);
         step();
      end
      drain_all();

      // Randomized traffic on a handful of words, with a reset mid-stream.
      for (int it = 0; it < 3000; it++) begin
         if (it == 1500) do_reset();
         word = 30'h40 + 30'($urandom_range(0, 3));
         set_in($urandom_range(0, 99) < 70,
                {word, 2'($urandom_range(0, 3))},
                4'($urandom_range(1, 15)),
                $urandom,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 99) < 40,
                30'h40 + 30'($urandom_range(0, 5)),
                $urandom_range(0, 19) == 0);
         step();
      end
      drain_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the store queue, between its released-store output and the data-cache/memory sub-unit write port.
- Accepts retired stores one per cycle and holds them in a small FIFO of word-aligned entries.
- Merges byte lanes of back-to-back stores to the same 32-bit word, then drains entries in order through a valid/ready request port.
- Also tells the load pipe when a load word-address matches a buffered store.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- ENABLE_MERGE, 1, 1 enables byte-lane merging into the youngest entry; 0 makes the block a plain FIFO.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- sq_valid  input  1  store queue has a released store at its head.
- sq_addr  input  32  byte address of the head store.
- sq_be  input  4  byte enables, already lane-aligned.
- sq_data  input  32  store data, already lane-aligned.
- sq_cache_op  input  1  head entry is a cache-management operation.
- sq_pop  output  1  store accepted this cycle (drives the store queue pop).
- mem_valid  output  1  oldest entry presented to memory.
- mem_ready  input  1  memory accepts the presented entry.
- mem_addr  output  30  word address of the oldest entry.
- mem_be  output  4  merged byte enables.
- mem_data  output  32  merged data.
- mem_cache_op  output  1  oldest entry is a cache op.
- load_addr  input  30  word address of the load in address-check stage.
- load_conflict  output  1  some valid entry matches load_addr.
- drain_req  input  1  fence/flush: stop merging until empty.
- empty  output  1  no valid entries.
- full  output  1  all entries valid.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - head, tail and count are cleared; all valid bits are cleared.
  - Outputs are then: mem_valid=0, empty=1, full=0, load_conflict=0, sq_pop=0.
  - A reset in the middle of a drain discards all entries; an outstanding mem handshake is abandoned.
- Storage:
  - Each entry holds {word_addr[29:0], be[3:0], data[31:0], cache_op, valid}.
  - Entries are register-based; head and tail are log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - count is a log2(DEPTH)+1-bit counter.
- Merge condition (combinational) requires all of:
  - ENABLE_MERGE=1 and sq_valid=1 and drain_req=0 and sq_cache_op=0;
  - count>=1;
  - the youngest entry (tail-1) is not a cache op;
  - the youngest entry's word_addr equals sq_addr[31:2];
  - the youngest entry is not the head entry, or mem_valid=0. A merge never modifies an entry that is on the mem port this cycle.
- Accept: sq_pop = sq_valid & (merge | ~full). full is the registered state at the start of the cycle; there is no same-cycle reuse of a slot freed by a drain.
  - On merge: for each lane with sq_be[i]=1, the youngest entry's data byte i is replaced and be[i] is set.
  - On a non-merge accept: the tail entry is written with be=sq_be, data=sq_data and cache_op; tail increments.
- Drain:
  - mem_valid = ~empty; mem_* come straight from the head entry registers.
  - On mem_valid & mem_ready the head is invalidated and head increments.
  - Data is visible on mem one cycle after sq_pop at the earliest.
  - mem_* must hold stable while mem_valid=1 and mem_ready=0.
- count update: count_next = count + (accept & ~merge) - (mem_valid & mem_ready). A simultaneous push and pop when count=DEPTH-1 keeps full=0.
- empty and full are registered, computed from count_next.
- load_conflict is combinational: the OR over entries of (valid & word_addr==load_addr). Cache-op entries are included (conservative).
- drain_req: while high, merging is disabled, but accepts still proceed. The upstream block holds sq_valid low until empty=1.

Decomposition:
- Add to cva5_types: the wb_entry_t struct {word_addr, be, data, cache_op}.
- No sub-module is needed; the conflict comparator is an inline generate loop.

Test Plan:
- Reset with garbage on inputs -> empty=1, full=0, mem_valid=0, sq_pop=0 on the first cycle after reset.
- Push sb 0x100 be=0001 data=0xAA, then sh 0x102 be=1100 data=0xBBBB0000, with mem_ready=0 and a prior entry at head -> one entry with be=1101, data=0xBBBB00AA; count increments by 1 only.
- Fill with 4 distinct word stores, mem_ready=0 -> full=1; a fifth non-mergeable sq_valid gets sq_pop=0. Then one cycle with mem_ready=1 and sq_valid -> sq_pop still 0 that cycle, 1 the next.
- Single entry at head with mem_valid=1, mem_ready=0; push the same word -> no merge; a new entry is allocated and head mem_data is unchanged.
- Cache op followed by a store to the same word -> two entries, drained in order; mem_cache_op = 1 then 0.
- Buffered store at word 0x40; load_addr=0x40 -> load_conflict=1. After that entry drains -> load_conflict=0 the following cycle. Tail wrap over 3×DEPTH pushes -> data drains in order with no loss.
